// File: rtl/mem_wb_stage.sv
// MEM stage: owns data memory and the MEM/WB register, with a host port for
// parked-pipeline memory access and saturating load/store counters.
module mem_wb_stage #(
  parameter int DATA_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH  = 3,
  parameter int DMEM_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       w_reg_en,
  input  logic                       w_mem_en,
  input  logic [DATA_WIDTH-1:0]      r1_out,
  input  logic [DATA_WIDTH-1:0]      r2_out,
  input  logic [REG_ADDR_WIDTH-1:0]  w_reg_1,
  input  logic                       host_sel,
  input  logic                       host_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]      host_wdata,
  output logic [DATA_WIDTH-1:0]      host_rdata,
  output logic                       host_rvalid,
  output logic                       wb_en_o,
  output logic [REG_ADDR_WIDTH-1:0]  wb_addr_o,
  output logic [DATA_WIDTH-1:0]      wb_data_o,
  output logic [31:0]                ld_count,
  output logic [31:0]                st_count
);

  localparam int DEPTH = 1 << DMEM_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]      mem [0:DEPTH-1];
  logic [DMEM_ADDR_WIDTH-1:0] pipe_addr;
  logic                       pipe_go;
  logic                       mem_we;
  logic [DMEM_ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       unused_addr_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
    if (inc && (cnt != 32'hFFFF_FFFF))
      return cnt + 32'd1;
    return cnt;
  endfunction

  assign pipe_addr        = r1_out[DMEM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^r1_out[DATA_WIDTH-1:DMEM_ADDR_WIDTH];
  assign pipe_go          = enable && !host_sel;

  // Host ownership takes effect at the same edge, dropping any pipeline store.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pipe_addr;
    mem_wdata = r2_out;
    if (host_sel) begin
      mem_we    = host_we;
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end else if (enable) begin
      mem_we = w_mem_en;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // MEM/WB register: reads sample the array before this edge's write (read-first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      ld_count    <= '0;
      st_count    <= '0;
    end else begin
      host_rvalid <= host_sel && !host_we;
      if (host_sel) begin
        wb_en_o <= 1'b0;
        if (!host_we)
          host_rdata <= mem[host_addr];
      end else if (pipe_go) begin
        wb_en_o   <= w_reg_en;
        wb_addr_o <= w_reg_1;
        wb_data_o <= w_reg_en ? mem[pipe_addr] : '0;
        ld_count  <= sat_inc(ld_count, w_reg_en);
        st_count  <= sat_inc(st_count, w_mem_en);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;

  localparam int DW = 64;
  localparam int RW = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable, w_reg_en, w_mem_en;
  logic [DW-1:0] r1_out, r2_out;
  logic [RW-1:0] w_reg_1;
  logic          host_sel, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_rvalid, wb_en_o;
  logic [RW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [31:0]   ld_count, st_count;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .w_reg_en(w_reg_en), .w_mem_en(w_mem_en),
    .r1_out(r1_out), .r2_out(r2_out), .w_reg_1(w_reg_1), .host_sel(host_sel),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .wb_en_o(wb_en_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .ld_count(ld_count), .st_count(st_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pipe(input logic en, input logic rd, input logic wr,
                      input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [RW-1:0] r);
    enable = en; w_reg_en = rd; w_mem_en = wr; r1_out = a; r2_out = d; w_reg_1 = r;
  endtask

  task automatic host(input logic sel, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_sel = sel; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_en"},  wb_en_o, 0);
    chk({tag, ".wb_addr"}, wb_addr_o, 0);
    chk({tag, ".wb_data"}, wb_data_o, 0);
    chk({tag, ".rdata"},  host_rdata, 0);
    chk({tag, ".rvalid"}, host_rvalid, 0);
    chk({tag, ".ld"},     ld_count, 0);
    chk({tag, ".st"},     st_count, 0);
  endtask

  initial begin
    pipe(1, 1, 1, 64'h3, 64'h1234, 3'd2);
    host(0, 0, 8'h0, 64'h0);

    // Asynchronous reset with traffic on the inputs
    #1 reset = 1'b1;
    #1 chk_all_zero("rst_async");
    step();
    step();
    chk_all_zero("rst_hold");
    reset = 1'b0;
    pipe(1, 0, 0, 64'h0, 64'h0, 3'd0);
    step();

    // Store then load
    pipe(1, 0, 1, 64'd5, 64'hDEAD_BEEF_0123_4567, 3'd0);
    step();
    chk("st1.wb_en", wb_en_o, 0);
    chk("st1.st", st_count, 1);
    pipe(1, 1, 0, 64'd5, 64'h0, 3'd3);
    step();
    chk("ld1.wb_en", wb_en_o, 1);
    chk("ld1.wb_addr", wb_addr_o, 3);
    chk("ld1.wb_data", wb_data_o, 64'hDEAD_BEEF_0123_4567);
    chk("ld1.ld", ld_count, 1);
    chk("ld1.st", st_count, 1);

    // Read-first on same-cycle load/store, then address aliasing
    pipe(1, 0, 1, 64'd7, 64'h11, 3'd0);
    step();
    pipe(1, 1, 1, 64'd7, 64'h22, 3'd5);
    step();
    chk("rf.wb_data", wb_data_o, 64'h11);
    chk("rf.wb_addr", wb_addr_o, 5);
    chk("rf.ld", ld_count, 2);
    chk("rf.st", st_count, 3);
    pipe(1, 1, 0, 64'hFF07, 64'h0, 3'd4);
    step();
    chk("alias.wb_data", wb_data_o, 64'h22);
    chk("alias.ld", ld_count, 3);

    // Stall
    pipe(1, 0, 1, 64'd9, 64'h99, 3'd0);
    step();
    chk("st9.wb_data", wb_data_o, 0);
    pipe(1, 1, 0, 64'd5, 64'h0, 3'd6);
    step();
    chk("pre_stall.ld", ld_count, 4);
    pipe(0, 1, 1, 64'd9, 64'h55, 3'd1);
    step();
    step();
    chk("stall.wb_en", wb_en_o, 1);
    chk("stall.wb_addr", wb_addr_o, 6);
    chk("stall.wb_data", wb_data_o, 64'hDEAD_BEEF_0123_4567);
    chk("stall.ld", ld_count, 4);
    chk("stall.st", st_count, 4);

    // Host mode: pipeline inputs still asserted but must be dropped
    pipe(1, 1, 1, 64'd9, 64'h55, 3'd1);
    host(1, 0, 8'd9, 64'h0);
    step();
    chk("h9.rvalid", host_rvalid, 1);
    chk("h9.rdata", host_rdata, 64'h99);
    chk("h9.wb_en", wb_en_o, 0);
    chk("h9.wb_addr", wb_addr_o, 6);
    chk("h9.wb_data", wb_data_o, 64'hDEAD_BEEF_0123_4567);
    chk("h9.ld", ld_count, 4);
    chk("h9.st", st_count, 4);
    pipe(1, 0, 1, 64'h20, 64'h77, 3'd0);
    host(1, 1, 8'h20, 64'hABCD);
    step();
    chk("hw.rvalid", host_rvalid, 0);
    host(1, 0, 8'h20, 64'h0);
    step();
    chk("hr20.rvalid", host_rvalid, 1);
    chk("hr20.rdata", host_rdata, 64'hABCD);
    host(1, 0, 8'd9, 64'h0);
    step();
    chk("hr9b.rvalid", host_rvalid, 1);
    chk("hr9b.rdata", host_rdata, 64'h99);
    pipe(1, 0, 0, 64'h0, 64'h0, 3'd0);
    host(0, 0, 8'h0, 64'h0);
    step();
    chk("hidle.rvalid", host_rvalid, 0);
    chk("hidle.rdata", host_rdata, 64'h99);
    chk("hidle.st", st_count, 4);

    // Reset mid host read: no pulse, memory preserved
    host(1, 0, 8'h20, 64'h0);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_mid");
    step();
    chk("rst_mid.rvalid2", host_rvalid, 0);
    reset = 1'b0;
    host(1, 0, 8'd5, 64'h0);
    step();
    chk("keep.rvalid", host_rvalid, 1);
    chk("keep.rdata", host_rdata, 64'hDEAD_BEEF_0123_4567);
    host(0, 0, 8'h0, 64'h0);

    // Load counter saturation
    force dut.ld_count = 32'hFFFF_FFFE;
    #1 release dut.ld_count;
    pipe(1, 1, 0, 64'd7, 64'h0, 3'd2);
    step();
    chk("sat1.ld", ld_count, 32'hFFFF_FFFF);
    step();
    chk("sat2.ld", ld_count, 32'hFFFF_FFFF);
    step();
    chk("sat3.ld", ld_count, 32'hFFFF_FFFF);
    chk("sat3.wb_data", wb_data_o, 64'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
